// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// The host side is a valid/ready byte stream. SCSN stays low until the byte tagged
// TX_LAST has been shifted, then is held for CS_HOLD cycles and kept high for
// at least CS_GAP cycles before the next frame.
// Optional: define SPI_MASTER_LOOPBACK_EN to sample the internal MOSI register
// instead of the MISO pin (internal loopback).
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,  // SCLK half-period in CLK cycles
    parameter int CS_HOLD = 2,  // SCSN low time after the last SCLK fall
    parameter int CS_GAP  = 4   // minimum SCSN high time between frames
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic [7:0] TX_DATA,
    input  logic       TX_LAST,
    output logic       RX_VALID,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       SCLK,
    output logic       SCSN,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int CMAX_A = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
    localparam int CMAX   = (CMAX_A > CS_GAP) ? CMAX_A : CS_GAP;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        NEXT  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;       // cycles spent in the current state/phase
    logic            phase_hi;  // 0: SCLK low half, 1: SCLK high half
    logic [2:0]      bit_q;     // bit currently on MOSI (7 down to 0)
    logic [6:0]      tx_sr;     // remaining bits; the bit on the wire lives in MOSI
    logic [7:0]      rx_sr;
    logic            last_q;
    logic            sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    // Loopback: receive what is being driven, the pin is left unused
    logic unused_miso;
    assign unused_miso = MISO;
    assign sample_bit  = MOSI;
`else
    assign sample_bit  = MISO;
`endif

    // Main controller FSM; every output is a register updated here
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            phase_hi <= 1'b0;
            bit_q    <= 3'd0;
            tx_sr    <= 7'd0;
            rx_sr    <= 8'd0;
            last_q   <= 1'b0;
            SCSN     <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            TX_READY <= 1'b1;
            RX_VALID <= 1'b0;
            RX_DATA  <= 8'd0;
            BUSY     <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            case (state)
                // IDLE and NEXT both accept a byte; NEXT simply keeps SCSN low
                IDLE, NEXT: begin
                    if (TX_VALID && TX_READY) begin
                        tx_sr    <= TX_DATA[6:0];
                        last_q   <= TX_LAST;
                        MOSI     <= TX_DATA[7];
                        SCSN     <= 1'b0;
                        TX_READY <= 1'b0;
                        BUSY     <= 1'b1;
                        bit_q    <= 3'd7;
                        phase_hi <= 1'b0;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!phase_hi) begin
                            // rising edge: sample the slave's bit
                            SCLK     <= 1'b1;
                            rx_sr    <= {rx_sr[6:0], sample_bit};
                            phase_hi <= 1'b1;
                        end else begin
                            // falling edge: advance MOSI or close the byte
                            SCLK     <= 1'b0;
                            phase_hi <= 1'b0;
                            if (bit_q != 3'd0) begin
                                MOSI  <= tx_sr[6];
                                tx_sr <= {tx_sr[5:0], 1'b0};
                                bit_q <= bit_q - 3'd1;
                            end else begin
                                RX_VALID <= 1'b1;
                                RX_DATA  <= rx_sr;
                                if (last_q) begin
                                    state <= HOLD;
                                end else begin
                                    state    <= NEXT;
                                    TX_READY <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        cnt   <= '0;
                        SCSN  <= 1'b1;
                        MOSI  <= 1'b0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        TX_READY <= 1'b1;
                        BUSY     <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    SCSN     <= 1'b1;
                    SCLK     <= 1'b0;
                    MOSI     <= 1'b0;
                    TX_READY <= 1'b1;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: timeline model of the SPI waveform, a mode-0 slave
// model on MISO, directed scenarios plus randomized frames.
module tb_spi_master_ctrl;

    localparam int D = 2;
    localparam int H = 2;
    localparam int G = 4;
    localparam int BYTE_CYC = 16 * D;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TX_VALID = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_LAST = 1'b0;
    logic       TX_READY, RX_VALID, BUSY, SCLK, SCSN, MOSI, MISO;
    logic [7:0] RX_DATA;

    spi_master_ctrl #(.CLK_DIV(D), .CS_HOLD(H), .CS_GAP(G)) dut (
        .CLK(CLK), .RST(RST), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .TX_DATA(TX_DATA), .TX_LAST(TX_LAST), .RX_VALID(RX_VALID),
        .RX_DATA(RX_DATA), .BUSY(BUSY), .SCLK(SCLK), .SCSN(SCSN),
        .MOSI(MOSI), .MISO(MISO)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model (mode 0, updates MISO on SCLK fall) -----
    logic [7:0] sbytes [0:255];
    logic [7:0] sidx = 8'd0;
    logic [7:0] s_cur = 8'h00;
    int         s_pos = 0;
    bit         s_loaded = 1'b0;
    logic       miso_r = 1'b0;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign MISO = 1'b0;
`else
    assign MISO = miso_r;
`endif

    always @(negedge SCSN) begin
        if (!s_loaded) begin
            s_cur = sbytes[sidx];
            sidx++;
            s_loaded = 1'b1;
            s_pos = 0;
        end
        miso_r = s_cur[7];
    end

    always @(posedge SCLK) if (SCSN === 1'b0) s_pos++;

    always @(negedge SCLK) begin
        if (SCSN === 1'b0) begin
            if (s_pos == 8) begin
                s_cur = sbytes[sidx];
                sidx++;
                s_pos = 0;
                s_loaded = 1'b1;
                miso_r = s_cur[7];
            end else begin
                miso_r = s_cur[3'(7 - s_pos)];
            end
        end
    end

    // An interrupted byte is thrown away by the slave as well
    always @(posedge SCSN) if (s_pos != 0) s_loaded = 1'b0;

    // ---------------- timeline reference model ---------------------------
    // n counts cycles since the accepting edge of the current byte.
    bit         started = 1'b0;
    bit         act = 1'b0;
    int         n = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_last = 1'b0;
    logic [7:0] m_exp = 8'h00;
    logic [7:0] midx = 8'd0;
    logic       e_ready = 1'b1, e_busy = 1'b0, e_scsn = 1'b1, e_sclk = 1'b0;
    logic       e_mosi = 1'b0, e_rxv = 1'b0;
    logic [7:0] e_rxd = 8'h00;

    always @(posedge CLK) begin
        started = 1'b1;
        if (RST) begin
            act = 1'b0;
            n = 0;
            e_rxd = 8'h00;
        end else if (TX_VALID && e_ready) begin
            act = 1'b1;
            n = 0;
            m_byte = TX_DATA;
            m_last = TX_LAST;
`ifdef SPI_MASTER_LOOPBACK_EN
            m_exp = TX_DATA;
`else
            m_exp = sbytes[midx];
`endif
            midx++;
        end else if (act) begin
            n++;
            if (m_last && n >= BYTE_CYC + H + G) act = 1'b0;
        end
        e_rxv = act && (n == BYTE_CYC);
        if (e_rxv) e_rxd = m_exp;
        if (!act) begin
            e_ready = 1; e_busy = 0; e_scsn = 1; e_sclk = 0; e_mosi = 0;
        end else if (n < BYTE_CYC) begin
            e_ready = 0; e_busy = 1; e_scsn = 0;
            e_sclk = ((n % (2 * D)) >= D);
            e_mosi = m_byte[3'(7 - n / (2 * D))];
        end else if (!m_last) begin
            e_ready = 1; e_busy = 1; e_scsn = 0; e_sclk = 0; e_mosi = m_byte[0];
        end else if (n < BYTE_CYC + H) begin
            e_ready = 0; e_busy = 1; e_scsn = 0; e_sclk = 0; e_mosi = m_byte[0];
        end else begin
            e_ready = 0; e_busy = 1; e_scsn = 1; e_sclk = 0; e_mosi = 0;
        end
    end

    // ---------------- compare + event counters (opposite edge) -----------
    int         scsn_low_cnt = 0, rise_cnt = 0, rxv_cnt = 0, nxt_cnt = 0, gap_cnt = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_cap = 8'h00;

    always @(negedge CLK) begin
        if (started) begin
            chk("TX_READY", TX_READY, e_ready);
            chk("BUSY", BUSY, e_busy);
            chk("SCSN", SCSN, e_scsn);
            chk("SCLK", SCLK, e_sclk);
            chk("MOSI", MOSI, e_mosi);
            chk("RX_VALID", RX_VALID, e_rxv);
            chk("RX_DATA", RX_DATA, e_rxd);
            if (SCSN === 1'b0) scsn_low_cnt++;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                rise_cnt++;
                mosi_cap = {mosi_cap[6:0], MOSI};
            end
            if (RX_VALID === 1'b1) rxv_cnt++;
            if (TX_READY === 1'b1 && BUSY === 1'b1) nxt_cnt++;
            if (SCSN === 1'b1 && BUSY === 1'b1) gap_cnt++;
            prev_sclk = SCLK;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    // Called at posedge+1; leaves TX_VALID asserted after the handshake.
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit hs;
        TX_VALID = 1'b1;
        TX_DATA  = d;
        TX_LAST  = last;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            hs = (TX_READY === 1'b1);
            @(posedge CLK);
            #1;
            if (hs) return;
        end
        errors++;
        $display("FAIL send_timeout: byte %h not accepted", d);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (BUSY === 1'b0) begin
                @(posedge CLK);
                #1;
                return;
            end
        end
        errors++;
        $display("FAIL idle_timeout: BUSY still %b", BUSY);
    endtask

    int r0, x0, s0, nx0, g0;

    task automatic snap();
        r0 = rise_cnt; x0 = rxv_cnt; s0 = scsn_low_cnt; nx0 = nxt_cnt; g0 = gap_cnt;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbytes[i] = 8'($urandom_range(0, 255));
        sbytes[0] = 8'h3C;
        sbytes[7] = 8'h96;
        sbytes[8] = 8'h69;

        // Reset held 3 cycles with TX_VALID high
        RST = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hFF; TX_LAST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_scsn", SCSN, 1'b1);
        chk("rst_ready", TX_READY, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_rxv_count", 8'(rxv_cnt), 8'd0);
        RST = 1'b0; TX_VALID = 1'b0;
        @(posedge CLK); #1;

        // Single byte A5, slave returns 3C
        snap();
        send_byte(8'hA5, 1'b1);
        TX_VALID = 1'b0;
        wait_idle();
        chk("single_mosi_bits", mosi_cap, 8'hA5);
        chk("single_rises", 8'(rise_cnt - r0), 8'd8);
        chk("single_scsn_low", 8'(scsn_low_cnt - s0), 8'd34);
        chk("single_rxv", 8'(rxv_cnt - x0), 8'd1);
        chk("single_rx_data", RX_DATA, `ifdef SPI_MASTER_LOOPBACK_EN 8'hA5 `else 8'h3C `endif);
        chk("single_gap", 8'(gap_cnt - g0), 8'd4);

        // 3-byte frame, TX_VALID held throughout
        snap();
        send_byte(8'h01, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'hFF, 1'b1);
        TX_VALID = 1'b0;
        wait_idle();
        chk("frame3_rises", 8'(rise_cnt - r0), 8'd24);
        chk("frame3_next_cycles", 8'(nxt_cnt - nx0), 8'd2);
        chk("frame3_rxv", 8'(rxv_cnt - x0), 8'd3);
        chk("frame3_scsn_low", 8'(scsn_low_cnt - s0), 8'd100);
        chk("frame3_last_mosi", mosi_cap, 8'hFF);

        // Host stalls 50 cycles between two bytes of one frame
        snap();
        send_byte(8'h3E, 1'b0);
        TX_VALID = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (TX_READY === 1'b1) break;
        end
        repeat (50) @(posedge CLK);
        #1;
        send_byte(8'hD1, 1'b1);
        TX_VALID = 1'b0;
        wait_idle();
        chk("stall_next_cycles", 8'(nxt_cnt - nx0), 8'd51);
        chk("stall_rises", 8'(rise_cnt - r0), 8'd16);
        chk("stall_mosi", mosi_cap, 8'hD1);

        // Reset after the 4th SCLK rise of a byte
        snap();
        send_byte(8'h3B, 1'b0);
        TX_VALID = 1'b0;
        for (int k = 0; k < 100 && (rise_cnt - r0) < 4; k++) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_scsn", SCSN, 1'b1);
        chk("midrst_sclk", SCLK, 1'b0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_no_rxv", 8'(rxv_cnt - x0), 8'd0);
        send_byte(8'h5A, 1'b1);
        TX_VALID = 1'b0;
        wait_idle();
        chk("after_rst_mosi", mosi_cap, 8'h5A);
        chk("after_rst_rx", RX_DATA, `ifdef SPI_MASTER_LOOPBACK_EN 8'h5A `else 8'h96 `endif);

        // Loopback byte (MISO pin tied 0 in the loopback build)
        send_byte(8'hC3, 1'b1);
        TX_VALID = 1'b0;
        wait_idle();
        chk("c3_rx", RX_DATA, `ifdef SPI_MASTER_LOOPBACK_EN 8'hC3 `else 8'h69 `endif);

        // Randomized frames with random host stalls
        for (int f = 0; f < 30; f++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                int st;
                st = $urandom_range(0, 3);
                if (st > 0) begin
                    TX_VALID = 1'b0;
                    repeat (st) @(posedge CLK);
                    #1;
                end
                send_byte(8'($urandom_range(0, 255)), (b == nb - 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                TX_VALID = 1'b0;
                wait_idle();
            end
        end
        TX_VALID = 1'b0;
        wait_idle();
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
